// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 decrypt engine.
package arc4_pkg;

    localparam int BYTE_W  = 8;
    localparam int S_DEPTH = 256;

    localparam logic [BYTE_W-1:0] PRINT_LO_DEFAULT = 8'h20;
    localparam logic [BYTE_W-1:0] PRINT_HI_DEFAULT = 8'h7E;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_KSA  = 3'd2,
        ST_LEN  = 3'd3,
        ST_PRGA = 3'd4,
        ST_DONE = 3'd5
    } arc4_state_t;

    function automatic logic in_range(input logic [BYTE_W-1:0] b,
                                      input logic [BYTE_W-1:0] lo,
                                      input logic [BYTE_W-1:0] hi);
        return (b >= lo) && (b <= hi);
    endfunction

endpackage

// File: rtl/arc4_key_mux.sv
// Key register with a wrapping byte index; presents key[i mod KEY_BYTES] to the KSA.
module arc4_key_mux
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      inc,
    input  logic [KEY_BYTES*8-1:0]    key,
    output logic [BYTE_W-1:0]         key_byte
);

    localparam int IDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KEY_BYTES - 1);

    logic [KEY_BYTES*8-1:0] key_q, key_d;
    logic [IDX_W-1:0]       idx_q, idx_d;

    // Load resets the index so every run starts at key byte 0.
    always_comb begin
        key_d = key_q;
        idx_d = idx_q;
        if (load) begin
            key_d = key;
            idx_d = '0;
        end else if (inc) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end
    end

    always_comb begin
        key_byte = 8'h00;
        for (int b = 0; b < KEY_BYTES; b++) begin
            key_byte = (idx_q == IDX_W'(b)) ? key_q[(KEY_BYTES-1-b)*BYTE_W +: BYTE_W] : key_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q <= '0;
            idx_q <= '0;
        end else begin
            key_q <= key_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/arc4_decrypt_engine.sv
// ARC4 decryptor: S-box init, key schedule, then PRGA over CT[1..L] into PT,
// with an optional printable-byte screen that aborts on the first bad byte.
module arc4_decrypt_engine
    import arc4_pkg::*;
#(
    parameter int                KEY_BYTES       = 3,
    parameter bit                CHECK_PRINTABLE = 1'b1,
    parameter logic [BYTE_W-1:0] PRINT_LO        = PRINT_LO_DEFAULT,
    parameter logic [BYTE_W-1:0] PRINT_HI        = PRINT_HI_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    input  logic [KEY_BYTES*8-1:0] key,
    output logic                   key_valid,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren,
    input  logic [7:0]             s_rddata,
    output logic [7:0]             ct_addr,
    input  logic [7:0]             ct_rddata,
    output logic [7:0]             pt_addr,
    output logic [7:0]             pt_wrdata,
    output logic                   pt_wren
);

    localparam logic [7:0] S_LAST = 8'(S_DEPTH - 1);

    arc4_state_t state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [7:0]  i_q, i_d, j_q, j_d, si_q, si_d, sum_q, sum_d;
    logic [7:0]  ct_q, ct_d, len_q, len_d;
    logic        res_q, res_d, rdy_q, rdy_d, key_valid_q, key_valid_d;
    logic [7:0]  s_addr_q, s_addr_d, s_wrdata_q, s_wrdata_d;
    logic [7:0]  ct_addr_q, ct_addr_d, pt_addr_q, pt_addr_d, pt_wrdata_q, pt_wrdata_d;
    logic        s_wren_q, s_wren_d, pt_wren_q, pt_wren_d;

    logic        accept_s, kidx_inc_s, pt_bad_s;
    logic [7:0]  key_byte_s, j_ksa_s, j_prga_s, pt_byte_s;

    arc4_key_mux #(.KEY_BYTES(KEY_BYTES)) u_key_mux (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .inc      (kidx_inc_s),
        .key      (key),
        .key_byte (key_byte_s)
    );

    assign j_ksa_s   = j_q + s_rddata + key_byte_s;
    assign j_prga_s  = j_q + s_rddata;
    assign pt_byte_s = s_rddata ^ ct_q;
    assign pt_bad_s  = CHECK_PRINTABLE && !in_range(pt_byte_s, PRINT_LO, PRINT_HI);

    // Next-state logic; a read issued on the bus in one step has its data in the step after.
    always_comb begin
        state_d = state_q;   step_d = step_q;
        i_d = i_q;   j_d = j_q;   si_d = si_q;   sum_d = sum_q;
        ct_d = ct_q; len_d = len_q; res_d = res_q;
        rdy_d = rdy_q;  key_valid_d = key_valid_q;
        s_addr_d = s_addr_q;   s_wrdata_d = s_wrdata_q;   s_wren_d = 1'b0;
        ct_addr_d = ct_addr_q; pt_addr_d = pt_addr_q;     pt_wrdata_d = pt_wrdata_q;
        pt_wren_d = 1'b0;
        accept_s = 1'b0;     kidx_inc_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    accept_s = 1'b1;   rdy_d = 1'b0;   state_d = ST_INIT;
                    i_d = 8'd0;   s_addr_d = 8'd0;   s_wrdata_d = 8'd0;   s_wren_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                if (i_q == S_LAST) begin
                    state_d = ST_KSA;  step_d = 3'd0;
                    i_d = 8'd0;   j_d = 8'd0;   s_addr_d = 8'd0;
                end else begin
                    i_d = i_q + 8'd1;  s_addr_d = i_q + 8'd1;  s_wrdata_d = i_q + 8'd1;  s_wren_d = 1'b1;
                end
            end
            // KSA: read S[i], read S[j], write S[j]=S[i], write S[i]=old S[j]
            ST_KSA: begin
                case (step_q)
                    3'd0: step_d = 3'd1;
                    3'd1: begin
                        si_d = s_rddata;  j_d = j_ksa_s;  s_addr_d = j_ksa_s;  step_d = 3'd2;
                    end
                    3'd2: begin
                        s_addr_d = j_q;  s_wrdata_d = si_q;  s_wren_d = 1'b1;  step_d = 3'd3;
                    end
                    3'd3: begin
                        s_addr_d = i_q;  s_wrdata_d = s_rddata;  s_wren_d = 1'b1;  step_d = 3'd4;
                    end
                    default: begin
                        kidx_inc_s = 1'b1;  step_d = 3'd0;
                        if (i_q == S_LAST) begin
                            state_d = ST_LEN;  ct_addr_d = 8'd0;
                        end else begin
                            i_d = i_q + 8'd1;  s_addr_d = i_q + 8'd1;
                        end
                    end
                endcase
            end
            ST_LEN: begin
                if (step_q == 3'd0) begin
                    step_d = 3'd1;
                end else begin
                    len_d = ct_rddata;  pt_addr_d = 8'd0;  pt_wrdata_d = ct_rddata;  pt_wren_d = 1'b1;
                    j_d = 8'd0;  step_d = 3'd0;
                    if (ct_rddata == 8'd0) begin
                        i_d = 8'd0;  res_d = 1'b1;  state_d = ST_DONE;
                    end else begin
                        i_d = 8'd1;  s_addr_d = 8'd1;  ct_addr_d = 8'd1;  state_d = ST_PRGA;
                    end
                end
            end
            ST_PRGA: begin
                case (step_q)
                    3'd0: step_d = 3'd1;
                    3'd1: begin
                        si_d = s_rddata;  ct_d = ct_rddata;  j_d = j_prga_s;  s_addr_d = j_prga_s;  step_d = 3'd2;
                    end
                    3'd2: begin
                        s_addr_d = j_q;  s_wrdata_d = si_q;  s_wren_d = 1'b1;  step_d = 3'd3;
                    end
                    3'd3: begin
                        sum_d = si_q + s_rddata;
                        s_addr_d = i_q;  s_wrdata_d = s_rddata;  s_wren_d = 1'b1;  step_d = 3'd4;
                    end
                    3'd4: begin
                        s_addr_d = sum_q;  step_d = 3'd5;
                    end
                    3'd5: step_d = 3'd6;
                    default: begin
                        // The offending byte is still written before aborting.
                        pt_addr_d = i_q;  pt_wrdata_d = pt_byte_s;  pt_wren_d = 1'b1;  step_d = 3'd0;
                        if (pt_bad_s) begin
                            res_d = 1'b0;  state_d = ST_DONE;
                        end else if (i_q == len_q) begin
                            res_d = 1'b1;  state_d = ST_DONE;
                        end else begin
                            i_d = i_q + 8'd1;  s_addr_d = i_q + 8'd1;  ct_addr_d = i_q + 8'd1;
                        end
                    end
                endcase
            end
            ST_DONE: begin
                rdy_d = 1'b1;  key_valid_d = res_q;  state_d = ST_IDLE;
            end
            default: begin
                rdy_d = 1'b1;  state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;  step_q <= 3'd0;
            i_q <= 8'd0;  j_q <= 8'd0;  si_q <= 8'd0;  sum_q <= 8'd0;
            ct_q <= 8'd0;  len_q <= 8'd0;  res_q <= 1'b0;
            rdy_q <= 1'b1;  key_valid_q <= 1'b0;
            s_addr_q <= 8'd0;  s_wrdata_q <= 8'd0;  s_wren_q <= 1'b0;
            ct_addr_q <= 8'd0;  pt_addr_q <= 8'd0;  pt_wrdata_q <= 8'd0;  pt_wren_q <= 1'b0;
        end else begin
            state_q <= state_d;  step_q <= step_d;
            i_q <= i_d;  j_q <= j_d;  si_q <= si_d;  sum_q <= sum_d;
            ct_q <= ct_d;  len_q <= len_d;  res_q <= res_d;
            rdy_q <= rdy_d;  key_valid_q <= key_valid_d;
            s_addr_q <= s_addr_d;  s_wrdata_q <= s_wrdata_d;  s_wren_q <= s_wren_d;
            ct_addr_q <= ct_addr_d;  pt_addr_q <= pt_addr_d;  pt_wrdata_q <= pt_wrdata_d;  pt_wren_q <= pt_wren_d;
        end
    end

    assign rdy       = rdy_q;
    assign key_valid = key_valid_q;
    assign s_addr    = s_addr_q;
    assign s_wrdata  = s_wrdata_q;
    assign s_wren    = s_wren_q;
    assign ct_addr   = ct_addr_q;
    assign pt_addr   = pt_addr_q;
    assign pt_wrdata = pt_wrdata_q;
    assign pt_wren   = pt_wren_q;

endmodule

// File: tb/tb_arc4_decrypt_engine.sv
// Bench: four engines (3/4/6-byte keys with screening, 3-byte key without) on modelled
// memories; known-answer table, hand-written reset/abort sequences, random runs vs a model.
module tb_arc4_decrypt_engine;

    localparam int NI = 4;
    localparam logic [NI-1:0][7:0] KB = {8'd3, 8'd6, 8'd4, 8'd3};
    localparam logic [NI-1:0]      CP = 4'b0111;
    localparam int BUDGET = 1540 + 7*256 + 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        en [NI];
    logic [47:0] key_in [NI];
    logic        rdy [NI], key_valid [NI], s_wren [NI], pt_wren [NI], clr [NI];
    logic [7:0]  s_addr [NI], s_wrdata [NI], s_rd [NI], ct_addr [NI], ct_rd [NI];
    logic [7:0]  pt_addr [NI], pt_wrdata [NI];
    logic [7:0]  s_mem [NI][256], ct_mem [NI][256], pt_mem [NI][256];
    int          pt_cnt [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        arc4_decrypt_engine #(
            .KEY_BYTES(int'(KB[g])), .CHECK_PRINTABLE(CP[g]), .PRINT_LO(8'h20), .PRINT_HI(8'h7E)
        ) u_dut (
            .clk(clk), .rst(rst), .en(en[g]), .rdy(rdy[g]),
            .key(key_in[g][int'(KB[g])*8-1:0]), .key_valid(key_valid[g]),
            .s_addr(s_addr[g]), .s_wrdata(s_wrdata[g]), .s_wren(s_wren[g]), .s_rddata(s_rd[g]),
            .ct_addr(ct_addr[g]), .ct_rddata(ct_rd[g]),
            .pt_addr(pt_addr[g]), .pt_wrdata(pt_wrdata[g]), .pt_wren(pt_wren[g])
        );
    end

    // Single-port synchronous memories, 1-cycle read latency; PT writes are counted.
    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (s_wren[g]) s_mem[g][s_addr[g]] <= s_wrdata[g];
            s_rd[g]  <= s_mem[g][s_addr[g]];
            ct_rd[g] <= ct_mem[g][ct_addr[g]];
            if (clr[g]) begin
                for (int a = 0; a < 256; a++) pt_mem[g][a] <= 8'hEE;
                pt_cnt[g] <= 0;
            end else if (pt_wren[g]) begin
                pt_mem[g][pt_addr[g]] <= pt_wrdata[g];
                pt_cnt[g] <= pt_cnt[g] + 1;
            end
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural reference: plain ARC4 keystream, then apply the length/screen rules.
    logic [7:0] ref_ks [256];
    logic [7:0] exp_pt [256];
    int         exp_last;
    logic       exp_valid;

    task automatic ref_keystream(input logic [47:0] key, input int klen);
        int s [256];
        int i, j, t;
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + s[n] + int'(key[(klen - 1 - (n % klen))*8 +: 8])) % 256;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        i = 0; j = 0; ref_ks[0] = 8'h00;
        for (int k = 1; k < 256; k++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            ref_ks[k] = 8'(s[(s[i] + s[j]) % 256]);
        end
    endtask

    task automatic ref_expect(input int g, input logic [47:0] key);
        logic [7:0] p;
        int len;
        ref_keystream(key, int'(KB[g]));
        len = int'(ct_mem[g][0]);
        exp_pt[0] = ct_mem[g][0]; exp_last = 0; exp_valid = 1'b1;
        for (int k = 1; k <= len; k++) begin
            p = ref_ks[k] ^ ct_mem[g][k];
            exp_pt[k] = p; exp_last = k;
            if (CP[g] && (p < 8'h20 || p > 8'h7E)) begin
                exp_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic start(input int g, input logic [47:0] key);
        clr[g] = 1'b1;
        @(negedge clk);
        clr[g] = 1'b0; en[g] = 1'b1; key_in[g] = key;
        @(negedge clk);
        en[g] = 1'b0;
    endtask

    task automatic wait_rdy(input int g, output int cycles);
        bit done = 1'b0;
        cycles = 1;
        for (int c = 0; c < BUDGET; c++) begin
            if (rdy[g]) begin done = 1'b1; break; end
            @(negedge clk);
            cycles++;
        end
        chk("rdy_timeout", 32'(done), 32'd1);
    endtask

    task automatic check_result(input int g, input string tag);
        int bad = 0;
        chk({tag, "_key_valid"}, 32'(key_valid[g]), 32'(exp_valid));
        for (int k = 0; k <= exp_last; k++)
            chk($sformatf("%s_pt[%0d]", tag, k), 32'(pt_mem[g][k]), 32'(exp_pt[k]));
        for (int k = exp_last + 1; k < 256; k++)
            if (pt_mem[g][k] !== 8'hEE) bad++;
        chk({tag, "_untouched"}, 32'(bad), 32'd0);
        chk({tag, "_pt_writes"}, 32'(pt_cnt[g]), 32'(exp_last + 1));
    endtask

    typedef struct packed {
        logic [1:0]   inst;
        logic [47:0]  key;
        logic [7:0]   nbytes;
        logic [127:0] ct;
        logic [127:0] pt;
        logic         valid;
    } vec_t;

    vec_t tbl [5];

    task automatic load_table(input int v);
        logic [127:0] ct, pt;
        int g, n;
        g = int'(tbl[v].inst); n = int'(tbl[v].nbytes);
        ct = tbl[v].ct; pt = tbl[v].pt;
        for (int k = 0; k < 256; k++) ct_mem[g][k] = (k < n) ? ct[127 - 8*k -: 8] : 8'($urandom);
        for (int k = 0; k < n; k++) exp_pt[k] = pt[127 - 8*k -: 8];
        exp_last = n - 1; exp_valid = tbl[v].valid;
    endtask

    initial begin
        int cyc, g, len;
        logic [47:0] key;
        logic [7:0] p;

        tbl[0] = '{2'd0, 48'h4B6579, 8'd10, {80'h09BBF316E8D940AF0AD3, 48'h0},
                   {80'h09506C61696E74657874, 48'h0}, 1'b1};
        tbl[1] = '{2'd1, 48'h57696B69, 8'd6, {48'h051021BF0420, 80'h0},
                   {48'h057065646961, 80'h0}, 1'b1};
        tbl[2] = '{2'd2, 48'h536563726574, 8'd15, {120'h0E45A01F645FC35B383552544B9BF5, 8'h0},
                   {120'h0E41747461636B206174206461776E, 8'h0}, 1'b1};
        tbl[3] = '{2'd0, 48'hABCDEF, 8'd1, 128'h0, 128'h0, 1'b1};
        tbl[4] = '{2'd3, 48'h4B6579, 8'd10, {80'h09BBF316E8D940AF0AD3, 48'h0},
                   {80'h09506C61696E74657874, 48'h0}, 1'b1};

        for (int n = 0; n < NI; n++) begin
            en[n] = 1'b0; key_in[n] = 48'h0; clr[n] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int n = 0; n < NI; n++) begin
            chk("reset_rdy", 32'(rdy[n]), 32'd1);
            chk("reset_key_valid", 32'(key_valid[n]), 32'd0);
            chk("reset_addrs", 32'({s_addr[n], ct_addr[n], pt_addr[n], s_wrdata[n]}), 32'd0);
            chk("reset_wren", 32'({s_wren[n], pt_wren[n], pt_wrdata[n]}), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Known-answer table.
        for (int v = 0; v < 5; v++) begin
            g = int'(tbl[v].inst);
            load_table(v);
            start(g, tbl[v].key);
            chk($sformatf("vec%0d_busy", v), 32'(rdy[g]), 32'd0);
            wait_rdy(g, cyc);
            chk($sformatf("vec%0d_latency_ok", v), 32'(cyc <= 1540 + 7*(int'(tbl[v].nbytes) - 1)), 32'd1);
            check_result(g, $sformatf("vec%0d", v));
        end

        // Wrong key: screen aborts early and later PT bytes stay untouched.
        load_table(0);
        ref_expect(0, 48'h000000);
        start(0, 48'h000000);
        wait_rdy(0, cyc);
        chk("badkey_key_valid_low", 32'(key_valid[0]), 32'd0);
        chk("badkey_early", 32'(cyc < 1539 + 7*9), 32'd1);
        check_result(0, "badkey");

        // Reset in the middle of KSA, then rerun the first vector.
        load_table(0);
        start(0, tbl[0].key);
        repeat (600) @(negedge clk);
        chk("midrun_busy", 32'(rdy[0]), 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_rdy", 32'(rdy[0]), 32'd1);
        chk("midrst_wren", 32'({s_wren[0], pt_wren[0]}), 32'd0);
        @(negedge clk);
        chk("midrst_hold", 32'({rdy[0], s_wren[0], pt_wren[0]}), 32'b100);
        rst = 1'b0;
        @(negedge clk);
        load_table(0);
        start(0, tbl[0].key);
        wait_rdy(0, cyc);
        check_result(0, "rerun");

        // Randomised runs against the reference model.
        for (int r = 0; r < 8; r++) begin
            g = r % NI;
            key = {$urandom(), $urandom()};
            len = (r == 1 || r == 3) ? 255 : int'($urandom_range(1, 40));
            ref_keystream(key, int'(KB[g]));
            ct_mem[g][0] = 8'(len);
            for (int k = 1; k < 256; k++) begin
                if (r % 2 == 1) begin
                    p = 8'($urandom_range(32'h20, 32'h7E));
                    ct_mem[g][k] = p ^ ref_ks[k];
                end else begin
                    ct_mem[g][k] = 8'($urandom());
                end
            end
            ref_expect(g, key);
            start(g, key);
            wait_rdy(g, cyc);
            check_result(g, $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
